ysyx_25030081_ifu: RTL and testbench
====================================

Name: ysyx_25030081_ifu

Overview:
- Instruction fetch unit: owns the architectural PC register and consumes the next-PC value produced by the next-PC logic.
- Issues one instruction-memory read per instruction over a valid/ready request channel and accepts a valid-only response.
- Hands the fetched instruction to decode with a valid/ready handshake.
- Waits for the execute/writeback commit pulse before latching next_pc and starting the next fetch (multi-cycle, non-pipelined core).

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TIMEOUT_W, 8, width of response watchdog; a fault fires after 2^TIMEOUT_W-1 cycles in WAIT.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  output  DATA_WIDTH  current PC; feeds next-PC logic and decode.
- next_pc  input  DATA_WIDTH  next PC from next-PC logic; sampled only on an accepted commit.
- commit  input  1  single-cycle pulse: current instruction retired, next_pc valid.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  DATA_WIDTH  fetch address, equals pc.
- imem_rsp_valid  input  1  response valid, no backpressure.
- imem_rsp_data  input  DATA_WIDTH  instruction word.
- imem_rsp_err  input  1  bus error qualifier with rsp_valid.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  DATA_WIDTH  registered instruction word.
- fault  output  1  sticky fetch fault.
- fault_cause  output  2  01 misaligned next_pc, 10 bus error, 11 timeout, 00 none.
- fetch_cnt  output  32  count of instructions handed to decode (wraps).

Behaviour:
- Reset is asynchronous on rst_n low and releases synchronously on the next edge. During reset:
  - pc=RESET_PC, inst=0, fetch_cnt=0, fault=0, fault_cause=00.
  - State=IDLE, so imem_req_valid=0 and inst_valid=0.
- States: IDLE, REQ, WAIT, HOLD, EXEC, FAULT. Outputs are Moore-decoded from state.
- IDLE: unconditional -> REQ on the next cycle. The first request is visible in the 2nd cycle after rst_n rises.
- REQ: imem_req_valid=1, addr=pc.
  - If imem_req_ready -> WAIT and the watchdog clears to 0.
  - valid holds and addr stays stable until ready.
- WAIT: the watchdog increments each cycle.
  - rsp_valid with rsp_err=0: inst<=rsp_data, -> HOLD.
  - rsp_valid with rsp_err=1: -> FAULT, cause 10.
  - Watchdog reaches 2^TIMEOUT_W-1 with no response: -> FAULT, cause 11.
  - A response arriving in the same cycle as the timeout wins (response is taken).
- HOLD: inst_valid=1, inst stable. On inst_ready: fetch_cnt+1 (mod 2^32), -> EXEC.
- EXEC: waits for commit.
  - commit with next_pc[1:0]==0: pc<=next_pc, -> REQ.
  - commit with next_pc[1:0]!=0: pc unchanged, -> FAULT, cause 01.
- FAULT: fault=1, all handshake outputs 0, and pc holds the faulting instruction's PC. Only reset exits this state.
- Latency, ideal memory (ready=1, response the cycle after acceptance): REQ 1 cycle + WAIT 1 cycle, so inst_valid rises 2 cycles after entering REQ.
- Ignored inputs (no state change):
  - commit in any state other than EXEC.
  - rsp_valid in any state other than WAIT (stale or spurious response).
  - inst_ready while inst_valid=0.
- Simultaneous commit and inst_ready cannot be meaningful; each is honoured only in its own state.
- Reset mid-operation (any state): immediate return to the reset values above. Any outstanding memory response after reset is dropped by the IDLE/REQ states.
- Widths:
  - pc and addr are DATA_WIDTH; no increment inside this block (pc+4 lives in next-PC logic).
  - The watchdog is TIMEOUT_W bits and saturates at terminal count, never wrapping.

Decomposition:
- Shared package/header ysyx_25030081_ifu_pkg holds:
  - State encoding (3-bit localparams IDLE..FAULT).
  - Fault cause codes (CAUSE_NONE/MISALIGN/BUSERR/TIMEOUT).
  - Default RESET_PC constant; the core top-level reuses it.
- One sub-module: ysyx_25030081_ifu_wdt, a saturating TIMEOUT_W counter with clr/en inputs and an expired output.

Test Plan:
- Reset release, ideal memory returning 32'h00000413: req_addr=32'h8000_0000 in cycle 2, inst_valid in cycle 4, inst=32'h00000413, fetch_cnt=1 after the inst_ready handshake.
- imem_req_ready held 0 for 5 cycles: req_valid stays 1 and addr stays 32'h8000_0000 throughout, then WAIT is entered; no duplicate request.
- Commit with next_pc=32'h8000_0010: next request addr=32'h8000_0010. Then commit next_pc=32'h8000_0012: fault=1, cause=01, pc stays 32'h8000_0010.
- Response with rsp_err=1: fault=1, cause=10, inst_valid never asserts. A further commit or rsp_valid changes nothing.
- No response, TIMEOUT_W=4: fault with cause=11 exactly 15 cycles after entering WAIT. A response arriving on cycle 15 instead yields HOLD with no fault.
- rst_n pulsed low while in HOLD with inst_ready=0: inst_valid drops immediately, pc=RESET_PC, fetch_cnt=0; a stray rsp_valid in IDLE is ignored.

Source files
------------

// File: rtl/ysyx_25030081_ifu_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, fault causes and reset PC.
package ysyx_25030081_ifu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4,
        FAULT = 3'd5
    } ifu_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030081_ifu_wdt.sv
// Saturating response watchdog; expired is raised in the cycle that reaches terminal count.
module ysyx_25030081_ifu_wdt #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] TC = '1;

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != TC) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Counting the current cycle: the TC-th enabled cycle is the expiring one.
    assign expired = (cnt == TC) || (en && cnt == TC - 1'b1);

endmodule

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit for a multi-cycle core: one fetch per retired instruction.
module ysyx_25030081_ifu
    import ysyx_25030081_ifu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    TIMEOUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic                  commit,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           fetch_cnt
);

    ifu_state_t state;
    logic       wdt_expired;

    ysyx_25030081_ifu_wdt #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == REQ && imem_req_ready),
        .en      (state == WAIT),
        .expired (wdt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inst        <= '0;
            fetch_cnt   <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    // A response in the expiring cycle still wins over the timeout.
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_BUSERR;
                        end else begin
                            inst  <= imem_rsp_data;
                            state <= HOLD;
                        end
                    end else if (wdt_expired) begin
                        state       <= FAULT;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (commit) begin
                        if (next_pc[1:0] == 2'b00) begin
                            pc    <= next_pc;
                            state <= REQ;
                        end else begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_MISALIGN;
                        end
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Directed bench for the fetch unit; inputs driven and outputs sampled on the falling edge.
module tb_ysyx_25030081_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc, next_pc, imem_req_addr, imem_rsp_data, inst, fetch_cnt;
    logic        commit, imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic        inst_valid, inst_ready, fault;
    logic [1:0]  fault_cause;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ysyx_25030081_ifu #(
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC),
        .TIMEOUT_W  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .next_pc        (next_pc),
        .commit         (commit),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Assert reset asynchronously, check, then release so the next edge is IDLE->REQ.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_ivalid", 32'(inst_valid), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n = 1'b0; commit = 1'b0; next_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        imem_rsp_err = 1'b0; inst_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("reset_pc", pc, RST_PC);
        chk("reset_inst", inst, 32'd0);
        chk("reset_cnt", fetch_cnt, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_cause", 32'(fault_cause), 32'd0);
        chk("reset_reqv", 32'(imem_req_valid), 32'd0);
        chk("reset_ivalid", 32'(inst_valid), 32'd0);

        // Ideal memory first fetch
        imem_req_ready = 1'b1;
        rst_n = 1'b1;                         // cycle 1: IDLE
        tick();                               // cycle 2: REQ
        chk("c2_reqv", 32'(imem_req_valid), 32'd1);
        chk("c2_addr", imem_req_addr, 32'h8000_0000);
        tick();                               // cycle 3: WAIT
        chk("c3_reqv", 32'(imem_req_valid), 32'd0);
        chk("c3_ivalid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
        tick();                               // cycle 4: HOLD
        imem_rsp_valid = 1'b0;
        chk("c4_ivalid", 32'(inst_valid), 32'd1);
        chk("c4_inst", inst, 32'h0000_0413);
        chk("c4_cnt", fetch_cnt, 32'd0);
        // Stray commit during HOLD is ignored
        commit = 1'b1; next_pc = 32'h8000_0040;
        tick();
        commit = 1'b0;
        chk("hold_commit_ivalid", 32'(inst_valid), 32'd1);
        chk("hold_commit_pc", pc, 32'h8000_0000);
        inst_ready = 1'b1;
        tick();                               // EXEC
        inst_ready = 1'b0;
        chk("exec_cnt", fetch_cnt, 32'd1);
        chk("exec_ivalid", 32'(inst_valid), 32'd0);

        // Commit aligned next_pc, then stall the request five cycles
        imem_req_ready = 1'b0;
        commit = 1'b1; next_pc = 32'h8000_0010;
        tick();
        commit = 1'b0;
        inst_ready = 1'b1;                    // no effect while inst_valid=0
        for (int i = 0; i < 5; i++) begin
            chk("stall_reqv", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, 32'h8000_0010);
            tick();
        end
        inst_ready = 1'b0;
        chk("stall_cnt", fetch_cnt, 32'd1);
        imem_req_ready = 1'b1;
        tick();                               // WAIT
        chk("post_stall_reqv", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        tick();                               // HOLD
        imem_rsp_valid = 1'b0;
        chk("f2_inst", inst, 32'h0010_0093);
        inst_ready = 1'b1;
        tick();                               // EXEC
        inst_ready = 1'b0;
        chk("f2_cnt", fetch_cnt, 32'd2);
        commit = 1'b1; next_pc = 32'h8000_0012;
        tick();                               // FAULT misaligned
        commit = 1'b0;
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_cause", 32'(fault_cause), 32'd1);
        chk("mis_pc", pc, 32'h8000_0010);
        chk("mis_reqv", 32'(imem_req_valid), 32'd0);

        // Bus error
        do_reset();
        chk("rst2_fault", 32'(fault), 32'd0);
        tick();                               // REQ
        tick();                               // WAIT
        imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();                               // FAULT
        chk("berr_fault", 32'(fault), 32'd1);
        chk("berr_cause", 32'(fault_cause), 32'd2);
        chk("berr_ivalid", 32'(inst_valid), 32'd0);
        imem_rsp_err = 1'b0; commit = 1'b1; next_pc = 32'h8000_0100;
        tick(); tick();
        imem_rsp_valid = 1'b0; commit = 1'b0;
        chk("berr_sticky_cause", 32'(fault_cause), 32'd2);
        chk("berr_sticky_pc", pc, 32'h8000_0000);
        chk("berr_sticky_inst", inst, 32'd0);
        chk("berr_sticky_ivalid", 32'(inst_valid), 32'd0);
        chk("berr_sticky_reqv", 32'(imem_req_valid), 32'd0);

        // Timeout: fault exactly 15 cycles after entering WAIT
        do_reset();
        tick();                               // REQ
        tick();                               // WAIT entered
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_pending", 32'(fault), 32'd0);
        end
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd3);

        // Response in the expiring cycle wins
        do_reset();
        tick();
        tick();
        for (int i = 1; i < 15; i++) tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hcafe_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("race_fault", 32'(fault), 32'd0);
        chk("race_ivalid", 32'(inst_valid), 32'd1);
        chk("race_inst", inst, 32'hcafe_0013);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        commit = 1'b1; next_pc = 32'h8000_0100;
        tick();                               // REQ
        commit = 1'b0;
        chk("race_addr", imem_req_addr, 32'h8000_0100);
        tick();                               // WAIT
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
        tick();                               // HOLD
        imem_rsp_valid = 1'b0;
        chk("pre_rst_ivalid", 32'(inst_valid), 32'd1);
        chk("pre_rst_cnt", fetch_cnt, 32'd1);

        // Reset mid-HOLD, then a stray response in IDLE
        rst_n = 1'b0;
        #1;
        chk("midrst_ivalid", 32'(inst_valid), 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_cnt", fetch_cnt, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        tick();
        imem_req_ready = 1'b0;
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdead_beef;
        tick();                               // REQ
        chk("stray_reqv", 32'(imem_req_valid), 32'd1);
        chk("stray_ivalid", 32'(inst_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        chk("stray_inst", inst, 32'd0);
        chk("stray_reqv2", 32'(imem_req_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
